seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Parametrised multi-cycle radix-2 restoring divider for the execute stage. Supports signed and unsigned modes and a configurable operand width. Handles flush, downstream stall and divide-by-zero explicitly. Holds its result until the consumer accepts it, so execute can stall on `is_div && !done`.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, kill any in-flight or held operation.
- stall, in, 1, downstream not ready; hold the result.
- en, in, 1, start request; sampled only in IDLE.
- is_signed, in, 1, two's-complement mode.
- dividend, in, WIDTH, numerator; sampled with en.
- divisor, in, WIDTH, denominator; sampled with en.
- quotient, out, WIDTH, result quotient; valid while done.
- remainder, out, WIDTH, result remainder; valid while done.
- done, out, 1, result valid.
- busy, out, 1, high in CALC or DONE.
- div_by_zero, out, 1, high with done when the captured divisor was 0.

Behaviour:
- Reset: async on rst_n low. State goes to IDLE; quotient, remainder, done, busy, div_by_zero and the counter all go to 0.
- States: IDLE, CALC, DONE. done=1 only in DONE; busy=1 in CALC or DONE.
- IDLE, en=1, flush=0:
  - Capture abs(dividend) and abs(divisor); abs is applied only if is_signed and the MSB is set.
  - Capture q_neg = sign(dividend) XOR sign(divisor), and r_neg = sign(dividend); both are forced to 0 when unsigned.
  - Capture the raw dividend for the divide-by-zero case.
  - Load counter = WIDTH.
  - divisor==0: go to DONE next cycle with quotient='1 (all ones), remainder=raw dividend, div_by_zero=1.
  - Otherwise go to CALC.
- CALC, one quotient bit per cycle:
  - Partial remainder P (WIDTH+1 bits) = {P, next dividend bit}.
  - If P >= |divisor|: P -= |divisor| and shift in 1; else shift in 0.
  - Decrement the counter. When it reaches 0, register the final result and go to DONE.
- Result fix-up, registered on the CALC->DONE transition:
  - quotient = q_neg ? -Q : Q.
  - remainder = r_neg ? -R : R.
  - Remainder sign always equals the dividend sign.
  - Signed overflow case (MIN / -1) falls out naturally: quotient = MIN, remainder = 0, no special state.
- Latency, no early-out:
  - en is sampled at edge 0. done=1 in cycle WIDTH+1 (33 cycles for WIDTH=32).
  - Divide-by-zero: done=1 in cycle 1.
- DONE:
  - Outputs stable while stall=1.
  - stall=0: go to IDLE next cycle; done drops, and quotient/remainder keep their last value.
  - en asserted in DONE is ignored.
- en asserted in CALC is ignored; operands are not resampled.
- flush:
  - In any state: go to IDLE next cycle; done and div_by_zero go to 0.
  - flush has priority over en, stall and counter expiry in the same cycle.
  - en+flush in IDLE does not start an operation.
- Back-to-back: a new en is accepted in the IDLE cycle immediately after DONE exits.
- No combinational path from inputs to done, quotient or remainder; all outputs are registered.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined, at capture in IDLE (checked after the divisor==0 check):
  - If |dividend| < |divisor|, go directly to DONE next cycle with quotient=0 and remainder=raw dividend.
  - Otherwise, preload the counter with WIDTH - clz(|dividend|) and pre-shift the dividend left by clz, so CALC runs only the significant bits.
  - Latency becomes 1 + (WIDTH - clz) cycles to done. Results are bit-identical to the non-early-out build.
- Undefined: fixed WIDTH-cycle CALC for every non-zero divisor; no clz logic is synthesised.

Test Plan:
- Unsigned, WIDTH=32: 100 / 7 -> done exactly 33 cycles after en; quotient=14, remainder=2, div_by_zero=0.
- Signed: -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned, same operands -> quotient=0, remainder=0x80000000.
- 5 / 0, unsigned -> done in cycle 1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Flush in CALC cycle 10:
  - done never asserts and busy=0 next cycle.
  - A following 1000 / 10 completes with quotient=100, remainder=0 at full latency.
- Stall in DONE:
  - Hold stall=1 for 3 cycles in DONE -> done and outputs stable; en pulses ignored.
  - Release stall -> done=0 next cycle.
  - With DIV_EARLY_OUT_EN, 3 / 9 -> done in cycle 1 with quotient=0, remainder=3.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with flush, stall and divide-by-zero handling.
// Optional leading-zero skip and small-dividend bypass when DIV_EARLY_OUT_EN is defined.
module seq_divider #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic             en,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_dec;
    logic [WIDTH:0]   p, p_sh, p_nxt;
    logic [WIDTH-1:0] a, a_nxt, dsr, a_abs, b_abs, q_fix, r_fix;
    logic             q_neg, r_neg, a_sign, b_sign, b_zero, ge, last;

    // 'a' shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        a_sign  = is_signed & dividend[WIDTH-1];
        b_sign  = is_signed & divisor[WIDTH-1];
        a_abs   = a_sign ? -dividend : dividend;
        b_abs   = b_sign ? -divisor : divisor;
        b_zero  = (divisor == '0);
        p_sh    = {p[WIDTH-1:0], a[WIDTH-1]};
        ge      = (p_sh >= {1'b0, dsr});
        p_nxt   = ge ? p_sh - {1'b0, dsr} : p_sh;
        a_nxt   = {a[WIDTH-2:0], ge};
        cnt_dec = cnt - CNT_W'(1);
        last    = (cnt_dec == '0);
        q_fix   = q_neg ? -a_nxt : a_nxt;
        r_fix   = r_neg ? -p_nxt[WIDTH-1:0] : p_nxt[WIDTH-1:0];
    end

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] clz;
    logic             found, small;

    always_comb begin
        clz   = '0;
        found = 1'b0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (!found) begin
                if (a_abs[i]) found = 1'b1;
                else          clz   = clz + CNT_W'(1);
            end
        end
        small = (a_abs < b_abs);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    if (b_zero) state_nxt = DONE;
`ifdef DIV_EARLY_OUT_EN
                    else if (small) state_nxt = DONE;
`endif
                    else state_nxt = CALC;
                end
            end
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (!stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            p           <= '0;
            a           <= '0;
            dsr         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        dsr         <= b_abs;
                        q_neg       <= a_sign ^ b_sign;
                        r_neg       <= a_sign;
                        p           <= '0;
                        a           <= a_abs;
                        cnt         <= CNT_W'(WIDTH);
                        div_by_zero <= b_zero;
                        if (b_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (small) begin
                            quotient  <= '0;
                            remainder <= dividend;
                        end else begin
                            // skip leading zeros so only significant bits are iterated
                            cnt <= CNT_W'(WIDTH) - clz;
                            a   <= a_abs << clz;
                        end
`endif
                    end
                end
                CALC: begin
                    p   <= p_nxt;
                    a   <= a_nxt;
                    cnt <= cnt_dec;
                    if (last) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                DONE:    if (!stall) div_by_zero <= 1'b0;
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_seq_divider.sv
// Randomized + directed scoreboard bench for seq_divider (WIDTH=32).
module tb_seq_divider;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         flush = 1'b0, stall = 1'b0, en = 1'b0, is_signed = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         done, busy, div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .en(en),
        .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .done(done), .busy(busy),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        int           lat;
        int           issue;
    } exp_t;

    exp_t sbq[$];
    int   total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference: language-level division; latency from operand magnitudes
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output bit dz, output int lat);
        longint sa, sb;
        logic [W-1:0] ma, mb;
        dz  = 1'b0;
        lat = W;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1; lat = 0;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
`ifdef DIV_EARLY_OUT_EN
        ma = (s && a[W-1]) ? -a : a;
        mb = (s && b[W-1]) ? -b : b;
        if (b != 0) begin
            if (ma < mb) lat = 0;
            else begin
                lat = 0;
                for (int i = 0; i < W; i++) if (ma[i]) lat = i + 1;
            end
        end
`else
        ma = a; mb = b;
        if (ma == mb) lat = lat;
`endif
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        chk("idle_wait", {63'd0, busy}, 64'd0);
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input bit push, input bit use_model,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz);
        exp_t e;
        logic [W-1:0] mq, mr;
        bit mdz;
        int lat;
        wait_idle();
        dividend = a; divisor = b; is_signed = s; en = 1'b1;
        if (push) begin
            model(a, b, s, mq, mr, mdz, lat);
            e.q     = use_model ? mq : eq;
            e.r     = use_model ? mr : er;
            e.dz    = use_model ? mdz : edz;
            e.lat   = lat;
            e.issue = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    // Monitor: one pop per rising done
    initial begin
        bit   done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done && !done_q) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("quotient", 64'(quotient), 64'(e.q));
                    chk("remainder", 64'(remainder), 64'(e.r));
                    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
                    chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                end
            end
            done_q = done;
        end
    end

    initial begin
        logic [W-1:0] hq, hr, ra, rb;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_flags", {61'd0, done, busy, div_by_zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 32'd14, 32'd2, 1'b0);
        start(-32'sd7, 32'd2, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        start(32'd7, -32'sd2, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd1, 1'b0);
        start(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'd0, 1'b0);
        start(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'd0, 32'h80000000, 1'b0);
        start(32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1);
`ifdef DIV_EARLY_OUT_EN
        start(32'd3, 32'd9, 1'b0, 1'b1, 1'b0, 32'd0, 32'd3, 1'b0);
`endif

        // flush mid-calculation, then a full-latency op
        start(32'd12345, 32'd3, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_done", {63'd0, done}, 64'd0);
        start(32'd1000, 32'd10, 1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 1'b0);

        // en with flush in IDLE must not start
        wait_idle();
        dividend = 32'd5; divisor = 32'd0; en = 1'b1; flush = 1'b1;
        @(negedge clk);
        en = 1'b0; flush = 1'b0;
        chk("en_flush_busy", {63'd0, busy}, 64'd0);

        // stall in DONE: outputs hold, en ignored, release drops done
        stall = 1'b1;
        start(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 32'd14, 32'd2, 1'b0);
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("stall_reach_done", {63'd0, done}, 64'd1);
        hq = quotient; hr = remainder;
        repeat (3) begin
            en = 1'b1; dividend = $urandom; divisor = $urandom;
            @(negedge clk);
            chk("stall_done", {63'd0, done}, 64'd1);
            chk("stall_q", 64'(quotient), 64'(hq));
            chk("stall_r", 64'(remainder), 64'(hr));
        end
        en = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("release_done", {63'd0, done}, 64'd0);
        chk("release_q_hold", 64'(quotient), 64'(hq));

        // randomized ops, occasionally with en pulses while busy
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: rb = '1;
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = W'($urandom_range(0, 300));
                default: ra = $urandom;
            endcase
            start(ra, rb, 1'($urandom_range(0, 1)), 1'b1, 1'b1, '0, '0, 1'b0);
            if (i % 4 == 0 && busy) begin
                en = 1'b1; dividend = $urandom; divisor = $urandom;
                @(negedge clk);
                en = 1'b0;
            end
        end

        n = 0;
        while (sbq.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
